mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the CPU data bus, downstream of the core's store path.
- The CPU writes bytes through the same data bus it uses for RAM: address, write data, per-byte write enables and combinational read data.
- The block queues bytes in a small FIFO and serialises them as 8N1 frames on a single tx line.
- The top-level address decoder drives sel.
- Reads are combinational, so a single-cycle load completes in the same cycle.

---
 rtl/mmio_uart_pkg.sv | 38 +++
 rtl/mmio_sync_fifo.sv | 59 +++++
 rtl/mmio_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register word offsets,
// STATUS bit positions and the transmitter state encoding.
package mmio_uart_pkg;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV    = 2'd2;
  localparam logic [1:0] UART_REG_RSVD   = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [31:0] uart_status(input logic       busy,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [3:0] cnt);
    logic [31:0] w;
    w                           = '0;
    w[STAT_BUSY]                = busy;
    w[STAT_FULL]                = full;
    w[STAT_EMPTY]               = empty;
    w[STAT_OVF]                 = ovf;
    w[STAT_CNT_LSB+3:STAT_CNT_LSB] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/mmio_sync_fifo.sv
// Single-clock FIFO with head-of-queue read port; push when full and pop when
// empty are ignored, so callers may drive push/pop without pre-qualifying.
module mmio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// CPU-bus UART transmitter: register decode, byte FIFO and an 8N1 shifter.
// States: IDLE line high | START low bit | DATA 8 bits LSB first | STOP high bit.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_DEFAULT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]           reg_idx;
  logic                 data_wr;
  logic                 stat_clr;
  logic                 div_wr;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 next_idle;
  logic                 irq_d;
  logic [DIV_WIDTH-1:0] div_eff;

  logic [DIV_WIDTH-1:0] div_q;
  logic                 ovf_q;

  uart_state_e          state_q;
  logic [7:0]           shift_q;
  logic [2:0]           bit_cnt_q;
  logic [DIV_WIDTH-1:0] baud_cnt_q;
  logic [DIV_WIDTH-1:0] div_lat_q;
  logic                 tx_q;
  logic                 irq_q;

  logic [7:0]           fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic                 unused_bits;

  assign unused_bits = ^{addr[1:0], wenable[3:2], wdata};

  assign reg_idx  = addr[3:2];
  assign data_wr  = sel & (reg_idx == UART_REG_DATA) & wenable[0];
  assign stat_clr = sel & (reg_idx == UART_REG_STATUS) & wenable[0] & wdata[STAT_OVF];
  assign div_wr   = sel & (reg_idx == UART_REG_DIV) & (wenable[0] | wenable[1]);

  // full is sampled before the edge, so a same-cycle pop never rescues a push
  assign push = data_wr & ~fifo_full;

  assign div_eff   = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign bit_end   = (baud_cnt_q == div_lat_q - DIV_WIDTH'(1));
  assign pop       = ~fifo_empty & ((state_q == UART_IDLE) |
                                    ((state_q == UART_STOP) & bit_end));
  assign next_idle = fifo_empty & ((state_q == UART_IDLE) |
                                   ((state_q == UART_STOP) & bit_end));
  // with the FIFO already empty and no pop, only this cycle's push can refill it
  assign irq_d     = next_idle & ~push;

  mmio_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wdata[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_WIDTH'(DIV_DEFAULT);
      ovf_q <= 1'b0;
    end else begin
      if (div_wr) div_q <= wdata[DIV_WIDTH-1:0];
      if (data_wr & fifo_full) begin
        ovf_q <= 1'b1;
      end else if (stat_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UART_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      div_lat_q  <= DIV_WIDTH'(1);
      tx_q       <= 1'b1;
      irq_q      <= 1'b1;
    end else begin
      irq_q <= irq_d;
      unique case (state_q)
        UART_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q    <= fifo_head;
            div_lat_q  <= div_eff;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b0;
            state_q    <= UART_START;
          end
        end
        UART_START: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            tx_q       <= shift_q[0];
            state_q    <= UART_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + DIV_WIDTH'(1);
          end
        end
        UART_DATA: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= UART_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + DIV_WIDTH'(1);
          end
        end
        UART_STOP: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (!fifo_empty) begin
              // chain straight into the next frame with no idle bit
              shift_q   <= fifo_head;
              div_lat_q <= div_eff;
              bit_cnt_q <= '0;
              tx_q      <= 1'b0;
              state_q   <= UART_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= UART_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + DIV_WIDTH'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= UART_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (reg_idx)
        UART_REG_STATUS: rdata = uart_status(state_q != UART_IDLE, fifo_full,
                                             fifo_empty, ovf_q, 4'(fifo_count));
        UART_REG_DIV:    rdata = 32'(div_q);
        default:         rdata = '0;
      endcase
    end
  end

  assign tx        = tx_q;
  assign irq_empty = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, chaining,
// overflow, mid-frame divisor change and asynchronous reset.
module tb_mmio_uart_tx;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wenable;
  logic [31:0] rdata;
  logic        tx;
  logic        irq_empty;

  int n_cmp;
  int n_err;

  logic [7:0] ovf_bytes [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                                 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

  mmio_uart_tx #(
    .FIFO_DEPTH  (8),
    .DIV_WIDTH   (16),
    .DIV_DEFAULT (434)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .addr      (addr),
    .wdata     (wdata),
    .wenable   (wenable),
    .rdata     (rdata),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic s, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] we);
    @(negedge clk);
    sel = s; addr = a; wdata = d; wenable = we;
    @(posedge clk);
    #1;
    sel = 1'b0; addr = '0; wdata = '0; wenable = '0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] v);
    sel = 1'b1; addr = a; wenable = '0;
    #1;
    v = rdata;
    sel = 1'b0; addr = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    peek(a, v);
  endtask

  // Called just after the edge that queued the byte into an idle block, or
  // right after the previous frame: checks every clock of the next frame.
  task automatic expect_frame(input logic [7:0] b, input int div, input string tag);
    logic e;
    int   bi;
    for (int j = 0; j < 10 * div; j++) begin
      @(posedge clk);
      @(negedge clk);
      bi = j / div;
      if (bi == 0)      e = 1'b0;
      else if (bi == 9) e = 1'b1;
      else              e = b[bi-1];
      check_eq(tag, 32'(tx), 32'(e));
    end
  endtask

  task automatic rx_byte(input int div, output logic [7:0] b, output logic ok);
    logic found;
    found = 1'b0;
    ok    = 1'b0;
    b     = '0;
    for (int t = 0; t < 20 * div && !found; t++) begin
      @(negedge clk);
      if (tx == 1'b0) found = 1'b1;
    end
    if (found) begin
      repeat (div / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (div) @(negedge clk);
        b[i] = tx;
      end
      repeat (div) @(negedge clk);
      ok = tx;
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  rb;
    logic        rok;

    n_cmp = 0;
    n_err = 0;
    sel = 1'b0; addr = '0; wdata = '0; wenable = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_irq", 32'(irq_empty), 32'd1);
    check_eq("rst_rdata_nosel", rdata, 32'd0);
    peek(4'h8, v);   check_eq("rst_div", v, 32'd434);
    peek(4'h4, v);   check_eq("rst_status", v, 32'h0000_0004);

    // single byte, 4 clocks per bit
    bus_write(1'b1, 4'h8, 32'd4, 4'b0001);
    bus_read(4'h8, v); check_eq("div_wr", v, 32'd4);
    bus_write(1'b1, 4'h0, 32'hA5, 4'b0001);
    expect_frame(8'hA5, 4, "a5_bit");
    peek(4'h4, v);   check_eq("a5_busy_k40", v, 32'h0000_0005);
    check_eq("a5_irq_k40", 32'(irq_empty), 32'd0);
    @(posedge clk); @(negedge clk);
    peek(4'h4, v);   check_eq("a5_idle_k41", v, 32'h0000_0004);
    check_eq("a5_irq_k41", 32'(irq_empty), 32'd1);

    // back-to-back frames with no idle gap
    bus_write(1'b1, 4'h0, 32'h55, 4'b0001);
    fork
      expect_frame(8'h55, 4, "b2b_first");
      bus_write(1'b1, 4'h0, 32'h0F, 4'b0001);
    join
    expect_frame(8'h0F, 4, "b2b_second");
    repeat (2) @(negedge clk);
    check_eq("b2b_irq", 32'(irq_empty), 32'd1);

    // divisor rewritten mid-frame applies only to the next frame
    bus_write(1'b1, 4'h0, 32'h3C, 4'b0001);
    fork
      expect_frame(8'h3C, 4, "midiv_old");
      begin
        repeat (10) @(negedge clk);
        bus_write(1'b1, 4'h8, 32'd2, 4'b0010);
      end
    join
    bus_read(4'h8, v); check_eq("midiv_reg", v, 32'd2);
    bus_write(1'b1, 4'h0, 32'hC3, 4'b0001);
    expect_frame(8'hC3, 2, "midiv_new");

    // decode isolation
    repeat (2) @(negedge clk);
    bus_write(1'b1, 4'h0, 32'h77, 4'b0010);
    repeat (2) @(negedge clk);
    peek(4'h4, v);   check_eq("we1_no_push", v, 32'h0000_0004);
    check_eq("we1_tx_idle", 32'(tx), 32'd1);
    bus_write(1'b0, 4'h8, 32'h9, 4'b1111);
    bus_read(4'h8, v); check_eq("nosel_div", v, 32'd2);
    bus_write(1'b0, 4'h0, 32'h12, 4'b1111);
    bus_read(4'h4, v); check_eq("nosel_data", v, 32'h0000_0004);
    bus_write(1'b1, 4'hC, 32'hFFFF_FFFF, 4'b1111);
    bus_read(4'hC, v); check_eq("rsvd_read", v, 32'd0);
    bus_read(4'h0, v); check_eq("data_read", v, 32'd0);
    bus_read(4'h8, v); check_eq("rsvd_wr_div", v, 32'd2);

    // divisor 0 behaves as 1 clock per bit
    bus_write(1'b1, 4'h8, 32'd0, 4'b0011);
    bus_read(4'h8, v); check_eq("div0_reg", v, 32'd0);
    bus_write(1'b1, 4'h0, 32'hA5, 4'b0001);
    expect_frame(8'hA5, 1, "div0_bit");

    // overflow: 1 in shifter + 8 queued, 10th dropped
    bus_write(1'b1, 4'h8, 32'd100, 4'b0001);
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          rx_byte(100, rb, rok);
          check_eq("ovf_rx_byte", 32'(rb), 32'(ovf_bytes[i]));
          check_eq("ovf_rx_stop", 32'(rok), 32'd1);
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          bus_write(1'b1, 4'h0, 32'(ovf_bytes[i]), 4'b0001);
        end
        bus_read(4'h4, v); check_eq("ovf_status", v, 32'h0000_080B);
        bus_write(1'b1, 4'h4, 32'h8, 4'b0001);
        bus_read(4'h4, v); check_eq("ovf_cleared", v, 32'h0000_0803);
      end
    join
    repeat (60) @(negedge clk);
    peek(4'h4, v);   check_eq("ovf_drained", v, 32'h0000_0004);
    check_eq("ovf_irq", 32'(irq_empty), 32'd1);

    // asynchronous reset in the middle of the data bits
    bus_write(1'b1, 4'h8, 32'd4, 4'b0001);
    bus_write(1'b1, 4'h0, 32'h00, 4'b0001);
    repeat (10) @(negedge clk);
    check_eq("rst_mid_low", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_tx", 32'(tx), 32'd1);
    check_eq("rst_mid_irq", 32'(irq_empty), 32'd1);
    peek(4'h4, v);   check_eq("rst_mid_status", v, 32'h0000_0004);
    peek(4'h8, v);   check_eq("rst_mid_div", v, 32'd434);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_post_tx", 32'(tx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
